controle_jogada_temporizada: RTL and testbench
==============================================

Name: controle_jogada_temporizada

Overview:
Parametrised next-generation control FSM for the ultimate tic-tac-toe datapath. It sequences macro-board choice, micro-cell choice, register strobes and turn change, like the current control unit. It adds:
- N-player rotation with an exported current-player index.
- Rejection of invalid moves without advancing.
- A per-move timeout that forfeits the turn.

It sits between the edge-detected button logic and the board/register datapath.

Parameters:
N_JOGADORES, 2, number of players in rotation (2..2**JOG_W)
JOG_W, 1, width of the jogador_atual index
TIMEOUT_CICLOS, 5000, clock cycles allowed per selection phase before the turn is forfeited (>=2)
TMR_W, 13, timer width; must satisfy 2**TMR_W > TIMEOUT_CICLOS

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high; returns FSM to inicial
iniciar  input  1  start / restart request (single-cycle pulse)
tem_jogada  input  1  single-cycle pulse: a selection was made
jogada_valida  input  1  qualifies tem_jogada: the selected cell/board is legal
fim_jogo  input  1  datapath reports the game has ended
escolhe_macro  input  1  next player must choose a macro board
zeraR_macro  output  1  clear macro register
zeraR_micro  output  1  clear micro register
registraR_macro  output  1  load macro register
registraR_micro  output  1  load micro register
jogar_macro  output  1  macro selection window open
jogar_micro  output  1  micro selection window open
jogador_atual  output  JOG_W  index of the player to move
erro_jogada  output  1  one-cycle pulse: invalid move rejected
timeout  output  1  one-cycle pulse: turn forfeited
pronto  output  1  game finished
db_estado  output  4  current state code

Behaviour:
- Moore FSM; all outputs decode Eatual, except erro_jogada and the player and timer registers.
- States and codes: inicial 0, preparacao 1, joga_macro 2, registra_macro 3, joga_micro 4, registra_micro 5, troca_jogador 6, decide_macro 7, estouro 8, fim F.
- Undefined codes go to inicial; db_estado shows 0 for them.
- Transitions:
  - inicial -> preparacao on iniciar.
  - preparacao -> joga_macro.
  - joga_macro -> registra_macro on tem_jogada & jogada_valida; -> estouro on timer expiry; else hold.
  - registra_macro -> joga_micro.
  - joga_micro -> registra_micro on tem_jogada & jogada_valida; -> estouro on expiry; else hold.
  - registra_micro -> troca_jogador.
  - estouro -> troca_jogador.
  - troca_jogador -> fim if fim_jogo, else decide_macro.
  - decide_macro -> preparacao if escolhe_macro, else registra_macro.
  - fim -> inicial on iniciar.
- Outputs:
  - zeraR_macro is 1 in inicial and preparacao.
  - zeraR_micro is 1 in inicial, preparacao and decide_macro.
  - Each of registraR_macro, registraR_micro, jogar_macro, jogar_micro is 1 only in its own state.
  - pronto is 1 in fim; timeout is 1 in estouro.
- Player register:
  - Cleared to 0 in inicial.
  - Incremented in troca_jogador, wrapping N_JOGADORES-1 -> 0.
  - Unchanged in all other states.
- Timer:
  - Cleared on any cycle where Eatual is not joga_macro or joga_micro, so it restarts at each selection window.
  - Increments every cycle inside a window.
  - Expiry = timer == TIMEOUT_CICLOS-1, with no valid move in the same cycle. The exit occurs on that edge, so the window lasts exactly TIMEOUT_CICLOS cycles.
- Invalid move:
  - Condition: tem_jogada & !jogada_valida in joga_macro or joga_micro.
  - FSM stays put; the timer is NOT restarted.
  - erro_jogada is registered high on the next cycle for exactly one cycle.
- Simultaneous events:
  - A valid move in the expiry cycle wins: registra_* is taken, no timeout.
  - An invalid move in the expiry cycle produces both erro_jogada and estouro.
- tem_jogada is ignored outside the joga states.
- Reset mid-game: all outputs return immediately to inicial values. That means zeraR_macro = zeraR_micro = 1, jogador_atual = 0, timer = 0, and all other outputs 0.

Optional Feature:
JOGADA_TIMEOUT_EN:
- Defined: timer, estouro state and timeout output as above.
- Undefined: no timer logic; estouro is unreachable; timeout is tied 0; the joga states wait indefinitely.

Test Plan:
1. TIMEOUT_CICLOS=8, reset, iniciar, valid macro after 3 cycles, valid micro after 2, fim_jogo=0, escolhe_macro=0 -> db_estado 1,2,..,3,4,..,5,6,7,3. jogador_atual 0->1 at leaving troca_jogador; registraR_* each high exactly one cycle.
2. N_JOGADORES=3, three complete turns -> jogador_atual 0,1,2,0.
3. Invalid tem_jogada in joga_micro -> state stays 4, erro_jogada high exactly one cycle later; the following valid move -> 5.
4. No input for 8 cycles in joga_macro -> estouro for one cycle, timeout=1, then troca_jogador; jogador_atual advances, registraR_macro never asserted.
5. Valid tem_jogada on expiry cycle (timer=7) -> registra_macro, timeout stays 0. fim_jogo=1 in troca_jogador -> fim, pronto=1; iniciar -> inicial.
6. Assert reset while in joga_micro with jogador_atual=1 -> db_estado=0, jogador_atual=0, zeraR_macro=zeraR_micro=1 immediately. Repeat test 4 without JOGADA_TIMEOUT_EN -> the FSM stays in state 2 after 20 idle cycles.

Source files
------------

// File: rtl/controle_jogada_temporizada.sv
// controle_jogada_temporizada: control FSM for the ultimate tic-tac-toe datapath.
// It sequences the macro-board choice, the micro-cell choice, the register strobes
// and the turn change. It rotates through N players and rejects invalid moves.
// Optional build macro JOGADA_TIMEOUT_EN adds a per-selection timeout that forfeits the turn.
// Without the macro, the selection states wait indefinitely and timeout stays 0.
module controle_jogada_temporizada #(
  parameter int unsigned N_JOGADORES    = 2,
  parameter int unsigned JOG_W          = 1,
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned TMR_W          = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             tem_jogada,
  input  logic             jogada_valida,
  input  logic             fim_jogo,
  input  logic             escolhe_macro,
  output logic             zeraR_macro,
  output logic             zeraR_micro,
  output logic             registraR_macro,
  output logic             registraR_micro,
  output logic             jogar_macro,
  output logic             jogar_micro,
  output logic [JOG_W-1:0] jogador_atual,
  output logic             erro_jogada,
  output logic             timeout,
  output logic             pronto,
  output logic [3:0]       db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    JOGA_MACRO     = 4'h2,
    REGISTRA_MACRO = 4'h3,
    JOGA_MICRO     = 4'h4,
    REGISTRA_MICRO = 4'h5,
    TROCA_JOGADOR  = 4'h6,
    DECIDE_MACRO   = 4'h7,
    ESTOURO        = 4'h8,
    FIM            = 4'hF
  } estado_t;

  estado_t eatual;
  estado_t eprox;
  logic    janela;
  logic    valida;
  logic    invalida;
  logic    expira;

  assign janela   = (eatual == JOGA_MACRO) || (eatual == JOGA_MICRO);
  assign valida   = janela && tem_jogada && jogada_valida;
  assign invalida = janela && tem_jogada && !jogada_valida;

`ifdef JOGADA_TIMEOUT_EN
  logic [TMR_W-1:0] timer;

  // Selection-window timer; restarts whenever the FSM is outside a window.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       timer <= '0;
    else if (janela) timer <= timer + TMR_W'(1);
    else             timer <= '0;
  end

  assign expira = janela && (timer == TMR_W'(TIMEOUT_CICLOS - 1));
`else
  logic [TMR_W-1:0] cfg_unused;
  assign cfg_unused = TMR_W'(TIMEOUT_CICLOS);
  assign expira     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) eatual <= INICIAL;
    else       eatual <= eprox;
  end

  // Next-state and Moore output decode; a valid move outranks expiry.
  always_comb begin
    eprox           = eatual;
    zeraR_macro     = 1'b0;
    zeraR_micro     = 1'b0;
    registraR_macro = 1'b0;
    registraR_micro = 1'b0;
    jogar_macro     = 1'b0;
    jogar_micro     = 1'b0;
    timeout         = 1'b0;
    pronto          = 1'b0;
    db_estado       = 4'h0;
    case (eatual)
      INICIAL: begin
        zeraR_macro = 1'b1;
        zeraR_micro = 1'b1;
        db_estado   = 4'h0;
        if (iniciar) eprox = PREPARACAO;
      end
      PREPARACAO: begin
        zeraR_macro = 1'b1;
        zeraR_micro = 1'b1;
        db_estado   = 4'h1;
        eprox       = JOGA_MACRO;
      end
      JOGA_MACRO: begin
        jogar_macro = 1'b1;
        db_estado   = 4'h2;
        if (valida)      eprox = REGISTRA_MACRO;
        else if (expira) eprox = ESTOURO;
      end
      REGISTRA_MACRO: begin
        registraR_macro = 1'b1;
        db_estado       = 4'h3;
        eprox           = JOGA_MICRO;
      end
      JOGA_MICRO: begin
        jogar_micro = 1'b1;
        db_estado   = 4'h4;
        if (valida)      eprox = REGISTRA_MICRO;
        else if (expira) eprox = ESTOURO;
      end
      REGISTRA_MICRO: begin
        registraR_micro = 1'b1;
        db_estado       = 4'h5;
        eprox           = TROCA_JOGADOR;
      end
      TROCA_JOGADOR: begin
        db_estado = 4'h6;
        eprox     = fim_jogo ? FIM : DECIDE_MACRO;
      end
      DECIDE_MACRO: begin
        zeraR_micro = 1'b1;
        db_estado   = 4'h7;
        eprox       = escolhe_macro ? PREPARACAO : REGISTRA_MACRO;
      end
      ESTOURO: begin
`ifdef JOGADA_TIMEOUT_EN
        timeout = 1'b1;
`endif
        db_estado = 4'h8;
        eprox     = TROCA_JOGADOR;
      end
      FIM: begin
        pronto    = 1'b1;
        db_estado = 4'hF;
        if (iniciar) eprox = INICIAL;
      end
      default: begin
        db_estado = 4'h0;
        eprox     = INICIAL;
      end
    endcase
  end

  // Player rotation: cleared in inicial, advanced once per troca_jogador.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogador_atual <= '0;
    end else if (eatual == INICIAL) begin
      jogador_atual <= '0;
    end else if (eatual == TROCA_JOGADOR) begin
      if (jogador_atual == JOG_W'(N_JOGADORES - 1)) jogador_atual <= '0;
      else                                          jogador_atual <= jogador_atual + JOG_W'(1);
    end
  end

  // One-cycle pulse flagging a rejected selection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) erro_jogada <= 1'b0;
    else       erro_jogada <= invalida;
  end

endmodule

// File: tb/tb_controle_jogada_temporizada.sv
// Directed self-checking bench for controle_jogada_temporizada (3 players, 8-cycle timeout).
module tb_controle_jogada_temporizada;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       tem_jogada;
  logic       jogada_valida;
  logic       fim_jogo;
  logic       escolhe_macro;
  logic       zeraR_macro;
  logic       zeraR_micro;
  logic       registraR_macro;
  logic       registraR_micro;
  logic       jogar_macro;
  logic       jogar_micro;
  logic [1:0] jogador_atual;
  logic       erro_jogada;
  logic       timeout;
  logic       pronto;
  logic [3:0] db_estado;

  int tests;
  int fails;

  controle_jogada_temporizada #(
    .N_JOGADORES(3), .JOG_W(2), .TIMEOUT_CICLOS(8), .TMR_W(4)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
    .jogada_valida(jogada_valida), .fim_jogo(fim_jogo), .escolhe_macro(escolhe_macro),
    .zeraR_macro(zeraR_macro), .zeraR_micro(zeraR_micro),
    .registraR_macro(registraR_macro), .registraR_micro(registraR_micro),
    .jogar_macro(jogar_macro), .jogar_micro(jogar_micro),
    .jogador_atual(jogador_atual), .erro_jogada(erro_jogada), .timeout(timeout),
    .pronto(pronto), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse_valid();
    tem_jogada = 1'b1; jogada_valida = 1'b1;
    tick();
    tem_jogada = 1'b0; jogada_valida = 1'b0;
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  // Drives one full turn from the first cycle of joga_macro back to it (escolhe_macro=1).
  task automatic play_turn();
    escolhe_macro = 1'b1;
    pulse_valid();  // 3
    tick();         // 4
    pulse_valid();  // 5
    tick();         // 6
    tick();         // 7
    tick();         // 1
    tick();         // 2
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tests++;
    if ({db_estado, zeraR_macro, zeraR_micro, jogador_atual} !== {4'h0, 1'b1, 1'b1, 2'd0}) begin
      fails++;
      $display("FAIL reset_state: got st=%h zm=%b zu=%b j=%0d, want st=0 zm=1 zu=1 j=0",
               db_estado, zeraR_macro, zeraR_micro, jogador_atual);
    end
    tests++;
    if ({registraR_macro, registraR_micro, jogar_macro, jogar_micro, erro_jogada, timeout, pronto} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {registraR_macro, registraR_micro, jogar_macro, jogar_micro, erro_jogada, timeout, pronto});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_turno();
    logic [3:0] seq [8];
    pulse_iniciar();
    tests++;
    if (db_estado !== 4'h1) begin fails++; $display("FAIL turno_prep: got %h want 1", db_estado); end
    tick();
    tests++;
    if ({db_estado, jogar_macro} !== {4'h2, 1'b1}) begin
      fails++; $display("FAIL turno_joga_macro: got st=%h jm=%b want st=2 jm=1", db_estado, jogar_macro);
    end
    tick(); tick();
    tests++;
    if (db_estado !== 4'h2) begin fails++; $display("FAIL turno_hold_macro: got %h want 2", db_estado); end
    pulse_valid();
    tests++;
    if ({db_estado, registraR_macro} !== {4'h3, 1'b1}) begin
      fails++; $display("FAIL turno_reg_macro: got st=%h rm=%b want st=3 rm=1", db_estado, registraR_macro);
    end
    tick();
    tests++;
    if ({db_estado, registraR_macro, jogar_micro} !== {4'h4, 1'b0, 1'b1}) begin
      fails++; $display("FAIL turno_joga_micro: got st=%h rm=%b ju=%b want st=4 rm=0 ju=1",
                        db_estado, registraR_macro, jogar_micro);
    end
    tick();
    pulse_valid();
    fim_jogo = 1'b0; escolhe_macro = 1'b0;
    seq[0] = 4'h5; seq[1] = 4'h6; seq[2] = 4'h7; seq[3] = 4'h3; seq[4] = 4'h4;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (db_estado !== seq[i]) begin
        fails++; $display("FAIL turno_seq[%0d]: got %h want %h", i, db_estado, seq[i]);
      end
      if (i == 0) begin
        tests++;
        if ({registraR_micro, jogador_atual} !== {1'b1, 2'd0}) begin
          fails++; $display("FAIL turno_reg_micro: got ru=%b j=%0d want ru=1 j=0", registraR_micro, jogador_atual);
        end
      end
      if (i == 2) begin
        tests++;
        if ({jogador_atual, zeraR_micro, registraR_micro} !== {2'd1, 1'b1, 1'b0}) begin
          fails++; $display("FAIL turno_decide: got j=%0d zu=%b ru=%b want j=1 zu=1 ru=0",
                            jogador_atual, zeraR_micro, registraR_micro);
        end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_invalido();
    tem_jogada = 1'b1; jogada_valida = 1'b0;
    tick();
    tem_jogada = 1'b0;
    tests++;
    if ({db_estado, erro_jogada} !== {4'h4, 1'b1}) begin
      fails++; $display("FAIL invalido_erro: got st=%h erro=%b want st=4 erro=1", db_estado, erro_jogada);
    end
    tick();
    tests++;
    if ({db_estado, erro_jogada} !== {4'h4, 1'b0}) begin
      fails++; $display("FAIL invalido_pulse_end: got st=%h erro=%b want st=4 erro=0", db_estado, erro_jogada);
    end
    pulse_valid();
    tests++;
    if (db_estado !== 4'h5) begin fails++; $display("FAIL invalido_then_valid: got %h want 5", db_estado); end
    escolhe_macro = 1'b1;
    tick(); tick();
    tests++;
    if ({db_estado, jogador_atual} !== {4'h7, 2'd2}) begin
      fails++; $display("FAIL invalido_turn: got st=%h j=%0d want st=7 j=2", db_estado, jogador_atual);
    end
    tick();
    tests++;
    if ({db_estado, zeraR_macro} !== {4'h1, 1'b1}) begin
      fails++; $display("FAIL invalido_prep: got st=%h zm=%b want st=1 zm=1", db_estado, zeraR_macro);
    end
    tick();
  endtask

`ifdef JOGADA_TIMEOUT_EN
  task automatic test_timeout();
    // Window 1: idle with an invalid tap at cycle 3; timer must not restart.
    for (int c = 1; c <= 7; c++) begin
      tests++;
      if ({db_estado, registraR_macro, timeout} !== {4'h2, 1'b0, 1'b0}) begin
        fails++; $display("FAIL timeout_window[%0d]: got st=%h rm=%b to=%b want st=2 rm=0 to=0",
                          c, db_estado, registraR_macro, timeout);
      end
      if (c == 4) begin
        tests++;
        if (erro_jogada !== 1'b1) begin fails++; $display("FAIL timeout_tap_erro: got %b want 1", erro_jogada); end
      end
      tem_jogada = (c == 3); jogada_valida = 1'b0;
      tick();
    end
    tem_jogada = 1'b0;
    tests++;
    if (db_estado !== 4'h2) begin fails++; $display("FAIL timeout_last_cycle: got %h want 2", db_estado); end
    tick();
    tests++;
    if ({db_estado, timeout, registraR_macro} !== {4'h8, 1'b1, 1'b0}) begin
      fails++; $display("FAIL timeout_estouro: got st=%h to=%b rm=%b want st=8 to=1 rm=0",
                        db_estado, timeout, registraR_macro);
    end
    tick();
    tests++;
    if ({db_estado, timeout} !== {4'h6, 1'b0}) begin
      fails++; $display("FAIL timeout_troca: got st=%h to=%b want st=6 to=0", db_estado, timeout);
    end
    tick();
    tests++;
    if (jogador_atual !== 2'd0) begin fails++; $display("FAIL timeout_wrap: got j=%0d want 0", jogador_atual); end
    tick(); tick();
    // Window 2: invalid tap exactly on the expiry cycle.
    for (int c = 1; c <= 7; c++) tick();
    tem_jogada = 1'b1; jogada_valida = 1'b0;
    tick();
    tem_jogada = 1'b0;
    tests++;
    if ({db_estado, timeout, erro_jogada} !== {4'h8, 1'b1, 1'b1}) begin
      fails++; $display("FAIL timeout_invalid_expiry: got st=%h to=%b erro=%b want st=8 to=1 erro=1",
                        db_estado, timeout, erro_jogada);
    end
    tick(); tick();
    tests++;
    if ({db_estado, jogador_atual} !== {4'h7, 2'd1}) begin
      fails++; $display("FAIL timeout_second_turn: got st=%h j=%0d want st=7 j=1", db_estado, jogador_atual);
    end
    tick(); tick();
  endtask
`else
  task automatic test_sem_timeout();
    for (int c = 0; c < 20; c++) tick();
    tests++;
    if ({db_estado, timeout} !== {4'h2, 1'b0}) begin
      fails++; $display("FAIL sem_timeout_hold: got st=%h to=%b want st=2 to=0", db_estado, timeout);
    end
  endtask
`endif

  task automatic test_fim();
    for (int c = 1; c <= 7; c++) tick();
    pulse_valid();
    tests++;
    if ({db_estado, timeout} !== {4'h3, 1'b0}) begin
      fails++; $display("FAIL fim_valid_on_expiry: got st=%h to=%b want st=3 to=0", db_estado, timeout);
    end
    tick();
    pulse_valid();
    tick();
    fim_jogo = 1'b1;
    tick();
    fim_jogo = 1'b0;
    tests++;
    if ({db_estado, pronto} !== {4'hF, 1'b1}) begin
      fails++; $display("FAIL fim_pronto: got st=%h pronto=%b want st=F pronto=1", db_estado, pronto);
    end
    tick();
    tests++;
    if (db_estado !== 4'hF) begin fails++; $display("FAIL fim_hold: got %h want F", db_estado); end
    pulse_iniciar();
    tests++;
    if ({db_estado, pronto, zeraR_macro} !== {4'h0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL fim_restart: got st=%h pronto=%b zm=%b want st=0 pronto=0 zm=1",
                        db_estado, pronto, zeraR_macro);
    end
  endtask

  task automatic test_rotacao();
    logic [1:0] exp_j [3];
    exp_j[0] = 2'd1; exp_j[1] = 2'd2; exp_j[2] = 2'd0;
    reset = 1'b1; tick(); reset = 1'b0;
    pulse_iniciar();
    tick();
    tests++;
    if ({db_estado, jogador_atual} !== {4'h2, 2'd0}) begin
      fails++; $display("FAIL rotacao_start: got st=%h j=%0d want st=2 j=0", db_estado, jogador_atual);
    end
    for (int t = 0; t < 3; t++) begin
      play_turn();
      tests++;
      if ({db_estado, jogador_atual} !== {4'h2, exp_j[t]}) begin
        fails++; $display("FAIL rotacao[%0d]: got st=%h j=%0d want st=2 j=%0d", t, db_estado, jogador_atual, exp_j[t]);
      end
    end
  endtask

  task automatic test_reset_meio();
    reset = 1'b1; tick(); reset = 1'b0;
    pulse_iniciar();
    tick();
    play_turn();
    pulse_valid();
    tick();
    tests++;
    if ({db_estado, jogador_atual} !== {4'h4, 2'd1}) begin
      fails++; $display("FAIL reset_meio_setup: got st=%h j=%0d want st=4 j=1", db_estado, jogador_atual);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({db_estado, jogador_atual, zeraR_macro, zeraR_micro, jogar_micro} !== {4'h0, 2'd0, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL reset_meio_async: got st=%h j=%0d zm=%b zu=%b ju=%b want st=0 j=0 zm=1 zu=1 ju=0",
                        db_estado, jogador_atual, zeraR_macro, zeraR_micro, jogar_micro);
    end
    tick();
    reset = 1'b0;
    tick();
    tests++;
    if (db_estado !== 4'h0) begin fails++; $display("FAIL reset_meio_after: got %h want 0", db_estado); end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; iniciar = 1'b0; tem_jogada = 1'b0; jogada_valida = 1'b0;
    fim_jogo = 1'b0; escolhe_macro = 1'b0;
    test_reset();
    test_turno();
    test_invalido();
`ifdef JOGADA_TIMEOUT_EN
    test_timeout();
`else
    test_sem_timeout();
`endif
    test_fim();
    test_rotacao();
    test_reset_meio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
